// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One result bit is resolved per CALC cycle; FIX applies sign correction and commits HI/LO.
module muldiv_hilo_unit #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               is_div_reg;
  logic               is_signed_reg;
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic               div0_reg;
  logic [WIDTH-1:0]   src0_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? ({WIDTH{1'b0}} - x) : x;
  endfunction

  // Mult: multiplier sits in acc[W-1:0] and is shifted out LSB first while the
  // partial product grows into the upper half. Div: dividend sits in acc[W-1:0]
  // and is shifted out MSB first while quotient bits shift in behind it.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
    rem_next  = div_shift;
    quo_next  = {acc_reg[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH+1]) begin
      rem_next = div_diff[WIDTH:0];
      quo_next = {acc_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Quotient/product sign follows the operand sign mismatch; remainder follows the dividend.
  always_comb begin
    neg_res  = is_signed_reg & (neg_a_reg ^ neg_b_reg);
    prod_fix = neg_res ? ({(2*WIDTH){1'b0}} - acc_reg) : acc_reg;
    quo_fix  = neg_res ? ({WIDTH{1'b0}} - acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
    rem_fix  = (is_signed_reg & neg_a_reg) ? ({WIDTH{1'b0}} - rem_reg[WIDTH-1:0])
                                           : rem_reg[WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      is_div_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      neg_a_reg     <= 1'b0;
      neg_b_reg     <= 1'b0;
      div0_reg      <= 1'b0;
      src0_reg      <= '0;
      opnd_reg      <= '0;
      acc_reg       <= '0;
      rem_reg       <= '0;
      count_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (!op_i[2]) begin
              is_div_reg    <= op_i[1];
              is_signed_reg <= ~op_i[0];
              neg_a_reg     <= ~op_i[0] & src0_i[WIDTH-1];
              neg_b_reg     <= ~op_i[0] & src1_i[WIDTH-1];
              div0_reg      <= op_i[1] && (src1_i == '0);
              src0_reg      <= src0_i;
              opnd_reg      <= op_i[1] ? mag(src1_i, ~op_i[0]) : mag(src0_i, ~op_i[0]);
              acc_reg       <= {{WIDTH{1'b0}},
                                (op_i[1] ? mag(src0_i, ~op_i[0]) : mag(src1_i, ~op_i[0]))};
              rem_reg       <= '0;
              count_reg     <= '0;
              busy_reg      <= 1'b1;
              state_reg     <= CALC;
            end else if (op_i[1:0] == 2'b00) begin
              hi_reg <= src0_i;
            end else if (op_i[1:0] == 2'b01) begin
              lo_reg <= src0_i;
            end
          end
        end
        CALC: begin
          if (is_div_reg) begin
            acc_reg[WIDTH-1:0] <= quo_next;
            rem_reg            <= rem_next;
          end else begin
            acc_reg <= mul_next;
          end
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          if (is_div_reg) begin
            if (div0_reg) begin
              hi_reg <= src0_reg;
              lo_reg <= DIV0_LO;
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: stimulus pushes arithmetic-model results,
// a monitor pops and compares on every done_o pulse.
module tb_muldiv_hilo_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd7;
  logic [31:0] src0_i = '0;
  logic [31:0] src1_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [63:0] exp_last;

  muldiv_hilo_unit dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .op_i   (op_i),
    .src0_i (src0_i),
    .src1_i (src1_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: {HI, LO}
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int     ai, bi;
    longint sa, sb_l, q, r;
    logic [63:0] p;
    ai = a;
    bi = b;
    sa = ai;
    sb_l = bi;
    case (op)
      3'd0: begin p = sa * sb_l; return p; end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_l;
        r = sa % sb_l;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk_i);
      if (done_o) begin
        done_seen++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          $display("txn result: hi=%h lo=%h (expect hi=%h lo=%h)", hi_o, lo_o, e[63:32], e[31:0]);
          check("result_hi", hi_o, e[63:32]);
          check("result_lo", lo_o, e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; drives the request for one edge and returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    src0_i  = a;
    src1_i  = b;
    if (op < 3'd4) begin
      exp_last = ref_model(op, a, b);
      sb.push_back(exp_last);
    end
    $display("txn issue: op=%0d src0=%h src1=%h", op, a, b);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // mode 0: quiet inputs, 1: toggle operands during CALC, 2: inject MTHI while busy
  task automatic wait_done(input int mode, input string name);
    int n = 0;
    int guard = 0;
    while (!done_o && guard < 100) begin
      if (busy_o) n++;
      if (n == 16) begin
        check({name, "_hold_hi"}, hi_o, hi_m);
        check({name, "_hold_lo"}, lo_o, lo_m);
      end
      if (mode == 1) begin
        op_i   = 3'($urandom_range(0, 7));
        src0_i = $urandom;
        src1_i = $urandom;
      end else if (mode == 2) begin
        start_i = (n == 5);
        op_i    = 3'd4;
        src0_i  = 32'hCAFE_F00D;
      end
      guard++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done_o expected done within 100 cycles", name);
    end
    if (mode != 2) check({name, "_busy_cycles"}, 32'(n), 32'd33);
    check({name, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
    hi_m = exp_last[63:32];
    lo_m = exp_last[31:0];
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    issue(op, a, b);
    wait_done(0, name);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          d0;

    repeat (3) @(negedge clk_i);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
    @(negedge clk_i);
    check("done_single_pulse", {31'd0, done_o}, 32'd0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd3, 32'd7, 32'd2, "divu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd3, 32'h0000_1234, 32'd0, "divu_zero");
    run_op(3'd2, 32'h8765_4321, 32'd0, "div_zero");

    // MTHI then MTLO on consecutive edges
    start_i = 1'b1; op_i = 3'd4; src0_i = 32'hDEAD_BEEF;
    $display("txn issue: op=4 src0=%h", src0_i);
    @(negedge clk_i);
    check("mthi_hi", hi_o, 32'hDEAD_BEEF);
    check("mthi_busy", {31'd0, busy_o}, 32'd0);
    op_i = 3'd5; src0_i = 32'h1234_5678;
    $display("txn issue: op=5 src0=%h", src0_i);
    @(negedge clk_i);
    start_i = 1'b0;
    check("mtlo_lo", lo_o, 32'h1234_5678);
    check("mtlo_hi_kept", hi_o, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'd0, busy_o}, 32'd0);
    check("mtlo_done", {31'd0, done_o}, 32'd0);
    hi_m = 32'hDEAD_BEEF;
    lo_m = 32'h1234_5678;

    // Undefined op is a no-op
    issue(3'd6, 32'h5555_5555, 32'h1);
    check("noop_busy", {31'd0, busy_o}, 32'd0);
    check("noop_hi", hi_o, hi_m);

    // MTHI while busy is dropped
    issue(3'd1, 32'h0001_0000, 32'h0003_0000);
    wait_done(2, "mthi_busy");

    // Back-to-back with operand toggling during CALC
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, "b2b_first");
    issue(3'd3, 32'd100, 32'd7);
    wait_done(1, "b2b_second");

    // Randomized operations
    for (int i = 0; i < 14; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      d0  = $urandom_range(0, 5);
      rb  = (d0 == 0) ? 32'd0 : (d0 == 1) ? 32'($urandom_range(1, 15)) :
            (d0 == 2) ? 32'hFFFF_FFFF : $urandom;
      issue(rop, ra, rb);
      wait_done(i % 2, "rand");
    end

    // Asynchronous reset in the middle of a DIV
    issue(3'd2, 32'hFFFF_FF9C, 32'd7);
    repeat (9) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    sb.delete();
    hi_m = '0;
    lo_m = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    d0 = done_seen;
    repeat (40) @(negedge clk_i);
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, "post_rst");

    @(negedge clk_i);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Iterative multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It consumes the same 32-bit rs/rt operands as the single-cycle ALU and produces the same 64-bit {HI,LO} result format. It spreads MULT/MULTU/DIV/DIVU over 33 cycles instead of a combinational loop. The core issues ops with a start/busy/done handshake and reads HI/LO directly for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits (only 32 is verified)
DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  request; accepted on a rising edge when start_i=1 and busy_o=0
op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-op
src0_i  in  32  rs (multiplicand / dividend / MTHI-MTLO data)
src1_i  in  32  rt (multiplier / divisor)
busy_o  out  1  registered; high while an iterative op is in flight
done_o  out  1  registered one-cycle pulse when HI/LO are updated by an iterative op
hi_o  out  32  registered HI (mult upper word / div remainder)
lo_o  out  32  registered LO (mult lower word / div quotient)

Behaviour:
- Reset (async, any state): state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0; the in-flight op is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start_i with op 000-011: latch op and operands, convert signed operands to magnitude, record signs, clear the iteration counter, go to CALC. busy_o=1 from the next cycle.
  - start_i with MTHI: hi_o<=src0_i on that edge.
  - start_i with MTLO: lo_o<=src0_i on that edge.
  - MTHI/MTLO stay in IDLE, keep busy_o=0 and produce no done_o.
  - Undefined op codes are ignored.
- CALC: exactly 32 cycles, counter 0..31, one bit per cycle.
  - Mult: shift-add on a 64-bit product accumulator.
  - Div: restoring shift-subtract on a 33-bit partial remainder.
  - After count 31, go to FIX.
- FIX: one cycle.
  - Apply sign correction and write hi_o/lo_o.
  - Assert done_o for exactly one cycle after this edge; busy_o falls on the same edge.
  - Go to IDLE.
- Latency: accept edge E0. HI/LO update on edge E33; done_o=1 and busy_o=0 in the cycle after E33. Back-to-back: a start on the cycle where done_o=1 is accepted.
- hi_o/lo_o keep their old values during CALC. No partial results are visible.
- start_i while busy_o=1 is ignored, including MTHI/MTLO. There is no queue; the requester must hold or retry.
- MULT: signed 64-bit product, HI=[63:32], LO=[31:0]. MULTU: unsigned product.
- DIV:
  - Quotient truncates toward zero; remainder takes the dividend's sign. HI=remainder, LO=quotient.
  - 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0, with no trap.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU, src1_i=0): full 33-cycle latency kept; HI=src0_i unchanged, LO=DIV0_LO.
- Operands are captured at accept. Changes to src0_i/src1_i/op_i during CALC have no effect.
- Mid-operation reset: outputs clear immediately (asynchronously); no done_o follows.

Test Plan:
- Reset, then MULT src0=0xFFFF_FFFE (-2), src1=0x0000_0003 -> busy_o high 33 cycles; done_o pulses once; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. Same operands with MULTU -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV src0=0xFFFF_FFF9 (-7), src1=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 7/2 -> LO=3, HI=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0. DIVU 0x1234/0 -> HI=0x0000_1234, LO=0xFFFF_FFFF after 33 cycles.
- MTHI 0xDEAD_BEEF then MTLO 0x1234_5678 on consecutive cycles -> hi_o/lo_o update one edge after each; busy_o and done_o stay 0. MULTU started, then MTHI issued while busy -> MTHI ignored; final HI is the product upper word.
- Back-to-back: MULTU 0xFFFF_FFFF*0xFFFF_FFFF, then start DIVU 100/7 in the done_o cycle -> first result HI=0xFFFF_FFFE, LO=0x0000_0001; second accepted immediately, giving LO=14, HI=2 33 cycles later; operand toggling during CALC does not change results.
- Assert rst_i asynchronously (between clock edges) at cycle 10 of a DIV -> busy_o, hi_o, lo_o are 0 immediately; no done_o follows; a new MULT 3*4 after release gives LO=12, HI=0.
